alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters: requester 0 is the integer pipe and requester 1 is the address/branch helper.
- Accepts one operation at a time using a valid/ready handshake and arbitrates round-robin.
- Registers the operands into the ALU, captures ALUOut and zero into a result register, and returns them to the granted requester with a valid/ready response handshake.
- Instantiates the existing ALU module internally. ALU ports: ALUCtl[3:0], A[31:0], B[31:0], ALUOut[31:0], zero.

Parameters:
- WIDTH, 32, operand/result width. Must equal the ALU width; only 32 is supported.
- FIRST_GRANT, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_ctl  input  4  ALUCtl code for requester 0
- req0_a  input  WIDTH  operand A for requester 0
- req0_b  input  WIDTH  operand B for requester 0
- rsp0_valid  output  1  result for requester 0 available
- rsp0_ready  input  1  requester 0 consumes the result
- req1_valid, req1_ready, req1_ctl, req1_a, req1_b, rsp1_valid, rsp1_ready  same as the requester 0 signals, for requester 1
- rsp_out  output  WIDTH  registered ALUOut (shared; qualified by rspN_valid)
- rsp_zero  output  1  registered zero flag (shared)
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE.
  - req0_ready, req1_ready, rsp0_valid, rsp1_valid and busy are all 0.
  - rsp_out is 0 and rsp_zero is 0.
  - Operand and control registers are 0.
  - last_grant is set to the inverse of FIRST_GRANT.
- States:
  - IDLE: waiting for a request.
  - EXEC: operands are held in the ALU input registers.
  - RESP: the result is held for the owner.
- IDLE:
  - A grant is computed combinationally from the two valids.
  - A single valid requester wins.
  - If both are valid, the requester not equal to last_grant wins.
  - The winner's reqN_ready is 1 in the same cycle; the loser's ready is 0.
  - On handshake (valid && ready):
    - latch ctl, a and b into the ALU input registers;
    - set owner to the winner and last_grant to the winner;
    - go to EXEC.
- EXEC: lasts exactly one cycle.
  - Captures ALU ALUOut into rsp_out and zero into rsp_zero.
  - Goes to RESP.
  - Both readys are 0.
- RESP:
  - rsp<owner>_valid is 1; the other response valid is 0.
  - rsp_out and rsp_zero hold stable until the owner asserts rspN_ready.
  - On rsp<owner>_valid && rsp<owner>_ready, go to IDLE. The next request can be granted in the following cycle, not in the same cycle.
  - rspN_ready from the non-owner is ignored.
- Latency: handshake at cycle N gives rsp valid at cycle N+2. Minimum issue interval is 3 cycles per operation with no back-pressure.
- Requester rule: once reqN_valid is asserted, the requester holds valid, ctl, a and b stable until ready. The arbiter does not check this.
- The arbiter never reorders or drops an accepted operation. There is one outstanding operation maximum.
- ALU semantics are passed through unchanged:
  - AND 0000, OR 0001, ADD 0010 (wraps mod 2^32), SUB 0110 (wraps), SLT 0111 (unsigned compare, result 0 or 1), NOR 1100.
  - Any other code gives rsp_out 0 and rsp_zero 1.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1 (FIRST_GRANT=0).
- Reset mid-operation, in EXEC or RESP:
  - the operation is discarded and no response is produced;
  - all outputs take their reset values within the reset assertion;
  - the first post-reset tie goes to FIRST_GRANT.
- busy is 1 in EXEC and RESP, and 0 in IDLE.

Test Plan:
- Reset, then a single request with req0 ADD: a=0x00000005, b=0x00000003, handshake at cycle N.
  - Required: rsp0_valid at N+2, rsp_out=0x00000008, rsp_zero=0, rsp1_valid stays 0.
- Both valid in the same cycle after reset: req0 SUB 7-7, req1 OR 0xF0|0x0F.
  - Required: req0 granted first with rsp_out=0 and rsp_zero=1.
  - Then req1 granted with rsp_out=0x000000FF.
  - Continued contention gives a grant order of 0,1,0,1.
- Back-pressure: req1 SLT a=0xFFFFFFFF, b=1, with rsp1_ready held low for 5 cycles.
  - Required: rsp1_valid stays 1 and rsp_out=0 stays stable.
  - req0_valid asserted meanwhile sees req0_ready=0 until the cycle after the rsp1 handshake.
- Wrap and unsupported codes:
  - ADD 0xFFFFFFFF+1 gives rsp_out=0, rsp_zero=1.
  - ctl=0101 gives rsp_out=0, rsp_zero=1.
  - NOR 0,0 gives 0xFFFFFFFF.
- Reset mid-op: drop rst_n during EXEC, then again during RESP.
  - Required: rsp0_valid, rsp1_valid and busy go to 0 immediately, with no late response after release.
  - With FIRST_GRANT=1, the post-reset tie grants req1.
- Wrong-owner ready: in RESP for owner 0, assert rsp1_ready only.
  - Required: the state stays RESP and rsp0_valid stays 1 until rsp0_ready is asserted.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between two requesters.
// Requester 0 is the integer pipe and requester 1 is the address/branch helper.
// Operations are accepted one at a time under round-robin arbitration.
// Each operation runs through IDLE -> EXEC -> RESP.
// The registered result is returned to the requester that owns the operation.

// Combinational ALU shared by both requesters.
module ALU (
    input  logic [3:0]  ALUCtl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUOut,
    output logic        zero
);

    // Operation decode; unsupported codes produce 0
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        ALUOut = 32'd0;
        case (ALUCtl)
            4'b0000: ALUOut = A & B;
            4'b0001: ALUOut = A | B;
            4'b0010: ALUOut = A + B;
            4'b0110: ALUOut = A - B;
            4'b0111: ALUOut = {31'd0, (A < B)};
            4'b1100: ALUOut = ~(A | B);
            default: ALUOut = 32'd0;
        endcase
    end

    assign zero = (ALUOut == 32'd0);

endmodule

module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter bit FIRST_GRANT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [3:0]       r_ctl;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_owner;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_rsp_out;
    logic             r_rsp_zero;

    logic             w_any_valid;
    logic             w_grant;
    logic             w_accept;
    logic             w_rsp_done;
    logic [31:0]      w_alu_out;
    logic             w_alu_zero;

    // A lone requester wins. On a tie the requester that did not win last time wins.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept    = (r_state == ST_IDLE) & w_any_valid;
    assign w_rsp_done  = (r_state == ST_RESP) & (r_owner ? rsp1_ready : rsp0_ready);

    ALU u_alu (
        .ALUCtl (r_ctl),
        .A      (r_a),
        .B      (r_b),
        .ALUOut (w_alu_out),
        .zero   (w_alu_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: EXEC always lasts one cycle, RESP waits for the owner's ready
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any_valid) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: if (w_rsp_done) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: request readies only in IDLE, response valid only for the owner in RESP
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = req0_valid & ~w_grant;
                req1_ready = w_grant;
            end
            ST_RESP: begin
                rsp0_valid = ~r_owner;
                rsp1_valid = r_owner;
            end
            default: ;
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign rsp_out  = r_rsp_out;
    assign rsp_zero = r_rsp_zero;

    // Datapath: latch the winner's operation on accept and capture the ALU result in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand and result registers are reset so a mid-operation reset leaves no stale result visible.
        if (!rst_n) begin
            r_ctl        <= 4'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= ~FIRST_GRANT;
            r_rsp_out    <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ctl        <= w_grant ? req1_ctl : req0_ctl;
                r_a          <= w_grant ? req1_a   : req0_a;
                r_b          <= w_grant ? req1_b   : req0_b;
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_out  <= w_alu_out;
                r_rsp_zero <= w_alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter.
// A transaction-level model predicts the readies, the response valids, busy and the results on every cycle.
// It tracks the single outstanding operation, its owner, when it is due and the round-robin history.
// The directed sequences also pin literal results.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [3:0]  req0_ctl, req1_ctl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, busy;
    logic [31:0] rsp_out;
    logic        f1_req0_ready, f1_req1_ready, f1_rsp0_valid, f1_rsp1_valid, f1_rsp_zero, f1_busy;
    logic [31:0] f1_rsp_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .FIRST_GRANT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
        .req0_a(req0_a), .req0_b(req0_b), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
        .req1_a(req1_a), .req1_b(req1_b), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_out(rsp_out), .rsp_zero(rsp_zero), .busy(busy)
    );

    // Second instance only used to observe the post-reset tie with FIRST_GRANT=1
    alu_arbiter #(.WIDTH(32), .FIRST_GRANT(1'b1)) u_dut_fg1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(f1_req0_ready), .req0_ctl(req0_ctl),
        .req0_a(req0_a), .req0_b(req0_b), .rsp0_valid(f1_rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(f1_req1_ready), .req1_ctl(req1_ctl),
        .req1_a(req1_a), .req1_b(req1_b), .rsp1_valid(f1_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_out(f1_rsp_out), .rsp_zero(f1_rsp_zero), .busy(f1_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: returns {zero, result}
    function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = (a < b) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    // ---------------- transaction model and per-cycle compare ----------------
    int          cyc = 0;
    bit          m_pend = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    int          m_due = 0;
    logic [32:0] m_res = '0;
    bit          m_g1, m_er0, m_er1, m_ev;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("rst_req0_ready", req0_ready, 0);
            check("rst_req1_ready", req1_ready, 0);
            check("rst_rsp0_valid", rsp0_valid, 0);
            check("rst_rsp1_valid", rsp1_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_rsp_out", rsp_out, 0);
            check("rst_rsp_zero", rsp_zero, 0);
            m_pend = 1'b0;
            m_last = 1'b1;
        end else begin
            m_g1  = req1_valid && (!req0_valid || !m_last);
            m_er0 = !m_pend && req0_valid && !m_g1;
            m_er1 = !m_pend && m_g1;
            m_ev  = m_pend && (cyc >= m_due);
            check("mon_req0_ready", req0_ready, m_er0);
            check("mon_req1_ready", req1_ready, m_er1);
            check("mon_rsp0_valid", rsp0_valid, m_ev && !m_owner);
            check("mon_rsp1_valid", rsp1_valid, m_ev && m_owner);
            check("mon_busy", busy, m_pend);
            if (m_ev) begin
                check("mon_rsp_out", rsp_out, m_res[31:0]);
                check("mon_rsp_zero", rsp_zero, m_res[32]);
                if (m_owner ? rsp1_ready : rsp0_ready) m_pend = 1'b0;
            end else if (m_er0 || m_er1) begin
                m_pend  = 1'b1;
                m_owner = m_er1;
                m_last  = m_er1;
                m_due   = cyc + 2;
                m_res   = m_er1 ? alu_ref(req1_ctl, req1_a, req1_b) : alu_ref(req0_ctl, req0_a, req0_b);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin
            req0_valid = v; req0_ctl = c; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_ctl = c; req1_a = a; req1_b = b;
        end
    endtask

    task automatic wait_ready(input int r);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((r == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_ready_in_time", ok, 1);
    endtask

    task automatic wait_rsp(input int r, output logic [31:0] out, output logic z);
        bit ok = 1'b0;
        out = '0;
        z = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((r == 0) ? rsp0_valid : rsp1_valid) begin
                ok = 1'b1;
                out = rsp_out;
                z = rsp_zero;
                break;
            end
        end
        check("wait_rsp_in_time", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle_in_time", ok, 1);
    endtask

    task automatic do_op(input int r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] out, output logic z);
        tick();
        drive(r, 1'b1, c, a, b);
        wait_ready(r);
        tick();
        drive(r, 1'b0, c, a, b);
        if (r == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        wait_rsp(r, out, z);
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_now_busy", busy, 0);
        check("rst_now_rsp0_valid", rsp0_valid, 0);
        check("rst_now_rsp1_valid", rsp1_valid, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic rnd_driver(input int r, input int n_ops);
        logic [3:0]  codes [8];
        logic [31:0] a, b;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0101, 4'b1111};
        for (int i = 0; i < n_ops; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            case ($urandom_range(0, 3))
                0: a = 32'd0;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = 32'd1;
                1: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            drive(r, 1'b1, codes[$urandom_range(0, 7)], a, b);
            wait_ready(r);
            tick();
            drive(r, 1'b0, 4'd0, 32'd0, 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] r_out;
    logic        r_z;
    bit          rnd_done;
    int          winner;

    initial begin
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_ctl = 0; req1_ctl = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single ADD from requester 0: response two cycles after the handshake
        tick();
        drive(0, 1'b1, 4'b0010, 32'd5, 32'd3);
        @(negedge clk);
        check("add_handshake_ready0", req0_ready, 1);
        tick();
        drive(0, 1'b0, 4'b0010, 32'd5, 32'd3);
        @(negedge clk);
        check("add_n1_rsp0_valid", rsp0_valid, 0);
        check("add_n1_busy", busy, 1);
        tick();
        @(negedge clk);
        check("add_n2_rsp0_valid", rsp0_valid, 1);
        check("add_n2_rsp1_valid", rsp1_valid, 0);
        check("add_rsp_out", rsp_out, 32'h0000_0008);
        check("add_rsp_zero", rsp_zero, 0);
        tick();
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // Tie after reset: 0 first, then 1, then strict alternation
        apply_reset();
        tick();
        drive(0, 1'b1, 4'b0110, 32'd7, 32'd7);
        drive(1, 1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("tie_ready0", req0_ready, 1);
        check("tie_ready1", req1_ready, 0);
        tick();
        drive(0, 1'b0, 4'b0110, 32'd7, 32'd7);
        wait_rsp(0, r_out, r_z);
        check("sub_rsp_out", r_out, 32'h0);
        check("sub_rsp_zero", r_z, 1);
        wait_ready(1);
        tick();
        drive(1, 1'b0, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
        wait_rsp(1, r_out, r_z);
        check("or_rsp_out", r_out, 32'h0000_00FF);
        tick();
        drive(0, 1'b1, 4'b0010, 32'd100, 32'd1);
        drive(1, 1'b1, 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0);
        for (int k = 0; k < 4; k++) begin
            bit ok = 1'b0;
            winner = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    ok = 1'b1;
                    winner = req1_ready ? 1 : 0;
                    break;
                end
            end
            check("contend_grant_seen", ok, 1);
            check("contend_grant_order", winner, k % 2);
            tick();
        end
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
        wait_idle();
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Back-pressure on requester 1 while requester 0 waits
        tick();
        drive(1, 1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
        wait_ready(1);
        tick();
        drive(1, 1'b0, 4'b0111, 32'hFFFF_FFFF, 32'd1);
        drive(0, 1'b1, 4'b0010, 32'd10, 32'd20);
        wait_rsp(1, r_out, r_z);
        check("slt_rsp_out", r_out, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("bp_rsp1_valid", rsp1_valid, 1);
            check("bp_rsp_out", rsp_out, 32'h0);
            check("bp_req0_ready", req0_ready, 0);
        end
        tick();
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("bp_req0_ready_at_hs", req0_ready, 0);
        tick();
        rsp1_ready = 1'b0;
        @(negedge clk);
        check("bp_req0_ready_after", req0_ready, 1);
        tick();
        drive(0, 1'b0, 4'b0010, 32'd10, 32'd20);
        rsp0_ready = 1'b1;
        wait_rsp(0, r_out, r_z);
        check("bp_add_rsp_out", r_out, 32'd30);
        tick();
        rsp0_ready = 1'b0;

        // Wrap-around and unsupported codes
        do_op(0, 4'b0010, 32'hFFFF_FFFF, 32'd1, r_out, r_z);
        check("wrap_rsp_out", r_out, 32'h0);
        check("wrap_rsp_zero", r_z, 1);
        do_op(1, 4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, r_out, r_z);
        check("unsup_rsp_out", r_out, 32'h0);
        check("unsup_rsp_zero", r_z, 1);
        do_op(0, 4'b1100, 32'h0, 32'h0, r_out, r_z);
        check("nor_rsp_out", r_out, 32'hFFFF_FFFF);
        check("nor_rsp_zero", r_z, 0);

        // Reset during EXEC
        tick();
        drive(0, 1'b1, 4'b0010, 32'd1, 32'd2);
        wait_ready(0);
        tick();
        drive(0, 1'b0, 4'b0010, 32'd1, 32'd2);
        check("pre_rst_exec_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("exec_rst_busy", busy, 0);
        check("exec_rst_rsp0_valid", rsp0_valid, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("exec_rst_no_late_rsp", rsp0_valid, 0);
        end

        // Reset during RESP
        tick();
        drive(1, 1'b1, 4'b0010, 32'd3, 32'd4);
        wait_ready(1);
        tick();
        drive(1, 1'b0, 4'b0010, 32'd3, 32'd4);
        tick();
        @(negedge clk);
        check("pre_rst_resp_rsp1_valid", rsp1_valid, 1);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("resp_rst_no_late_rsp", rsp1_valid, 0);
        end

        // First tie after reset follows FIRST_GRANT in each instance
        tick();
        drive(0, 1'b1, 4'b0000, 32'hF, 32'h3);
        drive(1, 1'b1, 4'b0001, 32'hF, 32'h3);
        @(negedge clk);
        check("fg0_tie_ready0", req0_ready, 1);
        check("fg1_tie_ready1", f1_req1_ready, 1);
        check("fg1_tie_ready0", f1_req0_ready, 0);
        tick();
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        wait_idle();
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Ready from the non-owner is ignored
        tick();
        drive(0, 1'b1, 4'b0010, 32'd40, 32'd2);
        rsp1_ready = 1'b1;
        wait_ready(0);
        tick();
        drive(0, 1'b0, 4'b0010, 32'd40, 32'd2);
        wait_rsp(0, r_out, r_z);
        check("wo_rsp_out", r_out, 32'd42);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("wo_rsp0_valid", rsp0_valid, 1);
            check("wo_busy", busy, 1);
        end
        tick();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b0;
        tick();
        rsp0_ready = 1'b0;
        @(negedge clk);
        check("wo_idle_after", busy, 0);

        // Randomized traffic from both requesters with random response back-pressure
        rnd_done = 1'b0;
        fork
            begin
                fork
                    rnd_driver(0, 40);
                    rnd_driver(1, 40);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tick();
                    rsp0_ready = ($urandom_range(0, 9) < 7);
                    rsp1_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        wait_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
